// File: rtl/fx_divider_multimode.sv
// Multicycle restoring fixed-point divider: signed/unsigned at runtime, remainder, saturation.
// Define FX_DIVIDER_ROUNDING_EN for round-half-to-even (adds a ROUND state); default truncates.
module fx_divider_multimode #(
  parameter int WIDTH = 32,
  parameter int FBITS = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             valid_o,
  output logic             dbz_o,
  output logic             ovf_o,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);
  localparam int ITER = WIDTH + FBITS;
  localparam int QW   = ITER + 1;
  localparam int CW   = $clog2(ITER + 1);

  localparam logic [QW-1:0]    LIM_NEG  = QW'(1) << (WIDTH - 1);
  localparam logic [QW-1:0]    LIM_POS  = LIM_NEG - QW'(1);
  localparam logic [QW-1:0]    LIM_U    = (QW'(1) << WIDTH) - QW'(1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS = ~MOST_NEG;

  typedef enum logic [1:0] {IDLE, CALC, ROUND, FINISH} state_t;

`ifdef FX_DIVIDER_ROUNDING_EN
  localparam state_t AFTER_CALC = ROUND;
`else
  localparam state_t AFTER_CALC = FINISH;
`endif

  state_t state_q, state_d;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [ITER-1:0]  dvd_q, dvd_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sdiff_q, sdiff_d, aneg_q, aneg_d, sgn_q, sgn_d, zdiv_q, zdiv_d;
  logic             busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic             dbz_q, dbz_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;

  logic [WIDTH-1:0] amag, bmag_in, diff;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [QW-1:0]    qmag;
  logic             qovf;

  // Most-negative signed input negates to 2^(WIDTH-1), which is exact as unsigned.
  assign amag    = (is_signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign bmag_in = (is_signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

  // The partial remainder stays below |b|, so its top trial bit lives only in the compare.
  assign trial = {acc_q, dvd_q[ITER-1]};
  assign ge    = trial >= {1'b0, bmag_q};
  assign diff  = trial[WIDTH-1:0] - bmag_q;

`ifdef FX_DIVIDER_ROUNDING_EN
  logic [QW-1:0]    mag_q, mag_d;
  logic [WIDTH:0]   gtrial;
  logic [WIDTH-1:0] gres;
  logic             guard, tie, rup;

  assign gtrial = {acc_q, 1'b0};
  assign guard  = gtrial >= {1'b0, bmag_q};
  assign gres   = gtrial[WIDTH-1:0] - bmag_q;
  assign tie    = guard && (gres == '0);
  assign rup    = guard && (!tie || dvd_q[0]);
  assign qmag   = mag_q;
`else
  assign qmag   = QW'(dvd_q);
`endif

  always_comb begin
    if (!sgn_q)       qovf = qmag > LIM_U;
    else if (sdiff_q) qovf = qmag > LIM_NEG;
    else              qovf = qmag > LIM_POS;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = (b_i == '0) ? FINISH : CALC;
      CALC:    if (cnt_q == CW'(ITER - 1)) state_d = AFTER_CALC;
      ROUND:   state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d   = acc_q;   dvd_d   = dvd_q;   bmag_d = bmag_q;  cnt_d  = cnt_q;
    sdiff_d = sdiff_q; aneg_d  = aneg_q;  sgn_d  = sgn_q;   zdiv_d = zdiv_q;
    busy_d  = busy_q;  done_d  = 1'b0;    valid_d = valid_q;
    dbz_d   = dbz_q;   ovf_d   = ovf_q;   quo_d  = quo_q;   rem_d  = rem_q;
`ifdef FX_DIVIDER_ROUNDING_EN
    mag_d   = mag_q;
`endif
    unique case (state_q)
      IDLE: if (start_i) begin
        valid_d = 1'b0;
        dbz_d   = 1'b0;
        ovf_d   = 1'b0;
        acc_d   = '0;
        cnt_d   = '0;
        dvd_d   = ITER'(amag) << FBITS;
        bmag_d  = bmag_in;
        sdiff_d = is_signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
        aneg_d  = is_signed_i & a_i[WIDTH-1];
        sgn_d   = is_signed_i;
        zdiv_d  = (b_i == '0);
        busy_d  = (b_i != '0);
      end
      CALC: begin
        acc_d = ge ? diff : trial[WIDTH-1:0];
        dvd_d = {dvd_q[ITER-2:0], ge};
        cnt_d = cnt_q + CW'(1);
      end
`ifdef FX_DIVIDER_ROUNDING_EN
      ROUND: mag_d = {1'b0, dvd_q} + QW'(rup);
`endif
      FINISH: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        if (zdiv_q) begin
          dbz_d = 1'b1;
          quo_d = '0;
          rem_d = '0;
        end else if (qovf) begin
          ovf_d = 1'b1;
          rem_d = '0;
          quo_d = !sgn_q ? '1 : (sdiff_q ? MOST_NEG : MOST_POS);
        end else begin
          valid_d = 1'b1;
          quo_d   = sdiff_q ? -qmag[WIDTH-1:0] : qmag[WIDTH-1:0];
          rem_d   = aneg_q ? -acc_q : acc_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0; dvd_q <= '0; bmag_q <= '0; cnt_q <= '0;
      sdiff_q <= 1'b0; aneg_q <= 1'b0; sgn_q <= 1'b0; zdiv_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0; valid_q <= 1'b0; dbz_q <= 1'b0; ovf_q <= 1'b0;
      quo_q <= '0; rem_q <= '0;
`ifdef FX_DIVIDER_ROUNDING_EN
      mag_q <= '0;
`endif
    end else begin
      acc_q <= acc_d; dvd_q <= dvd_d; bmag_q <= bmag_d; cnt_q <= cnt_d;
      sdiff_q <= sdiff_d; aneg_q <= aneg_d; sgn_q <= sgn_d; zdiv_q <= zdiv_d;
      busy_q <= busy_d; done_q <= done_d; valid_q <= valid_d; dbz_q <= dbz_d; ovf_q <= ovf_d;
      quo_q <= quo_d; rem_q <= rem_d;
`ifdef FX_DIVIDER_ROUNDING_EN
      mag_q <= mag_d;
`endif
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign valid_o = valid_q;
  assign dbz_o   = dbz_q;
  assign ovf_o   = ovf_q;
  assign quo_o   = quo_q;
  assign rem_o   = rem_q;

endmodule
